regbank_arbiter: RTL and testbench

- Round-robin arbiter that shares one DW-bit register (a bank of positive-edge D flip-flops) between NREQ requesters.
- Each requester raises req with its write data. The arbiter grants one requester at a time and bounds each grant to MAX_HOLD write cycles.
- Sits between requesting datapath blocks and the shared state register; it is the sequencer for that register.

---
 rtl/regbank_arbiter.sv | 154 +++++++++++++++
 tb/tb_regbank_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regbank_arbiter.sv
// Round-robin arbiter sequencing writes from NREQ requesters into one shared DW-bit register.
// Optional REGBANK_LOCK_EN: a holder asserting lock may extend its grant past MAX_HOLD writes.
module regbank_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      wdata,
  input  logic                    lock,
  output logic [NREQ-1:0]         gnt,
  output logic [DW-1:0]           q,
  output logic                    q_valid,
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int PW = $clog2(NREQ);
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_r, state_n;
  logic [PW-1:0]   ptr_r, ptr_n;
  logic [PW-1:0]   holder_r, holder_n;
  logic [3:0]      hold_cnt_r, hold_n;
  logic [NREQ-1:0] gnt_r, gnt_n;
  logic [DW-1:0]   q_r, q_n;
  logic            q_valid_r, q_valid_n;
  logic [PW-1:0]   owner_r, owner_n;
  logic            found_s;
  logic            release_s;
  logic [PW-1:0]   sel_s;
  logic [PW-1:0]   idx_s;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    if (v == PW'(NREQ - 1)) begin
      return {PW{1'b0}};
    end else begin
      return v + PW'(1);
    end
  endfunction

`ifndef REGBANK_LOCK_EN
  logic unused_lock;
  assign unused_lock = lock;
`endif

  // Next-state, round-robin selection and write decision.
  always_comb begin
    state_n   = state_r;
    ptr_n     = ptr_r;
    holder_n  = holder_r;
    hold_n    = hold_cnt_r;
    gnt_n     = gnt_r;
    q_n       = q_r;
    q_valid_n = 1'b0;
    owner_n   = owner_r;
    found_s   = 1'b0;
    release_s = 1'b0;
    sel_s     = {PW{1'b0}};
    idx_s     = {PW{1'b0}};
    case (state_r)
      IDLE: begin
        // Scan starting at ptr so the most recent holder is considered last.
        for (int k = 0; k < NREQ; k++) begin
          idx_s = PW'((int'(ptr_r) + k) % NREQ);
          if (!found_s && req[idx_s]) begin
            found_s = 1'b1;
            sel_s   = idx_s;
          end else begin
            found_s = found_s;
          end
        end
        if (found_s) begin
          state_n  = GRANT;
          holder_n = sel_s;
          hold_n   = 4'd0;
          gnt_n    = NREQ'(1) << sel_s;
        end else begin
          gnt_n = {NREQ{1'b0}};
        end
      end
      GRANT: begin
        if (req[holder_r]) begin
          q_n       = wdata[int'(holder_r)*DW +: DW];
          owner_n   = holder_r;
          q_valid_n = 1'b1;
          if (hold_cnt_r == HOLD_LAST) begin
`ifdef REGBANK_LOCK_EN
            if (lock) begin
              hold_n = hold_cnt_r;
            end else begin
              release_s = 1'b1;
            end
`else
            release_s = 1'b1;
`endif
          end else begin
            hold_n = hold_cnt_r + 4'd1;
          end
        end else begin
          release_s = 1'b1;
        end
        if (release_s) begin
          state_n = IDLE;
          gnt_n   = {NREQ{1'b0}};
          ptr_n   = wrap_inc(holder_r);
          hold_n  = 4'd0;
        end else begin
          state_n = GRANT;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = {NREQ{1'b0}};
        hold_n  = 4'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= {PW{1'b0}};
      holder_r   <= {PW{1'b0}};
      hold_cnt_r <= 4'd0;
      gnt_r      <= {NREQ{1'b0}};
      q_r        <= {DW{1'b0}};
      q_valid_r  <= 1'b0;
      owner_r    <= {PW{1'b0}};
    end else begin
      state_r    <= state_n;
      ptr_r      <= ptr_n;
      holder_r   <= holder_n;
      hold_cnt_r <= hold_n;
      gnt_r      <= gnt_n;
      q_r        <= q_n;
      q_valid_r  <= q_valid_n;
      owner_r    <= owner_n;
    end
  end

  assign gnt     = gnt_r;
  assign q       = q_r;
  assign q_valid = q_valid_r;
  assign owner   = owner_r;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Scoreboard bench for regbank_arbiter: directed scenarios plus random traffic against a
// grant/write-count reference model.
module tb_regbank_arbiter;

  localparam int NREQ     = 4;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;
`ifdef REGBANK_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [3:0]      req;
  logic [31:0]     wdata;
  logic            lock;
  logic [3:0]      gnt;
  logic [7:0]      q;
  logic            q_valid;
  logic [1:0]      owner;

  regbank_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .lock(lock),
    .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         o;
  } wr_t;

  wr_t        wr_q[$];
  logic [3:0] gnt_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the register and how many writes it has made.
  int         m_holder = -1;
  int         m_ptr    = 0;
  int         m_writes = 0;
  int         m_h;
  int         m_i;
  bit         m_keep;
  logic [3:0] m_gnt;
  wr_t        m_w;

  always @(posedge clk) begin
    m_gnt = 4'b0000;
    if (!rst_n) begin
      m_holder = -1;
      m_ptr    = 0;
      m_writes = 0;
    end else if (m_holder < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        m_i = (m_ptr + k) % NREQ;
        if (m_holder < 0 && req[m_i]) begin
          m_holder = m_i;
          m_writes = 0;
        end
      end
      if (m_holder >= 0) m_gnt = 4'b0001 << m_holder;
    end else begin
      m_h    = m_holder;
      m_keep = 1'b1;
      if (req[m_h]) begin
        m_w.d = wdata[m_h*DW +: DW];
        m_w.o = m_h;
        wr_q.push_back(m_w);
        if (m_writes >= MAX_HOLD - 1 && !(LOCK_EN && lock)) m_keep = 1'b0;
        else m_writes++;
      end else begin
        m_keep = 1'b0;
      end
      if (m_keep) begin
        m_gnt = 4'b0001 << m_h;
      end else begin
        m_ptr    = (m_h + 1) % NREQ;
        m_holder = -1;
      end
    end
    gnt_q.push_back(m_gnt);
  end

  // Monitor: compares every cycle's grant and every presented write.
  logic [7:0] last_q = 8'h00;
  logic [3:0] e_gnt;
  wr_t        e_w;

  always @(posedge clk) begin
    #1;
    if (!rst_n) last_q = 8'h00;
    if (gnt_q.size() == 0) begin
      check("gnt_queue_empty", 32'd1, 32'd0);
    end else begin
      e_gnt = gnt_q.pop_front();
      check("gnt", {28'd0, gnt}, {28'd0, e_gnt});
      check("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
    end
    if (q_valid) begin
      if (wr_q.size() == 0) begin
        check("spurious_write", {31'd0, q_valid}, 32'd0);
      end else begin
        e_w = wr_q.pop_front();
        check("q", {24'd0, q}, {24'd0, e_w.d});
        check("owner", {30'd0, owner}, e_w.o);
        last_q = e_w.d;
      end
    end else begin
      check("q_hold", {24'd0, q}, {24'd0, last_q});
    end
  end

  task automatic drive(input logic [3:0] r, input logic [31:0] wd, input logic l);
    @(negedge clk);
    req   = r;
    wdata = wd;
    lock  = l;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    wdata = 32'h0;
    lock  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a grant.
    repeat (3) drive(4'b0010, 32'h0000_3C00, 1'b0);
    @(negedge clk);
    check("pre_reset_gnt", {28'd0, gnt}, 32'h2);
    check("pre_reset_q", {24'd0, q}, 32'h3C);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", {28'd0, gnt}, 32'h0);
    check("async_q", {24'd0, q}, 32'h0);
    check("async_q_valid", {31'd0, q_valid}, 32'h0);
    check("async_owner", {30'd0, owner}, 32'h0);
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b1;

    // Single requester.
    repeat (3) drive(4'b0100, 32'h00A5_0000, 1'b0);
    repeat (2) drive(4'b0000, 32'h0, 1'b0);

    // Fairness from reset.
    reset_pulse();
    repeat (26) drive(4'b1111, $urandom, 1'b0);
    repeat (2) drive(4'b0000, 32'h0, 1'b0);

    // Hold limit with incrementing lane 1.
    reset_pulse();
    for (int i = 0; i < 12; i++) drive(4'b0010, {16'h0, 8'(i + 1), 8'h0}, 1'b0);
    repeat (2) drive(4'b0000, 32'h0, 1'b0);

    // Early release by requester 3 with requester 0 pending.
    reset_pulse();
    drive(4'b1000, 32'h5100_0000, 1'b0);
    drive(4'b1001, 32'h5200_0011, 1'b0);
    drive(4'b1001, 32'h5300_0012, 1'b0);
    repeat (4) drive(4'b0001, 32'h0000_0013, 1'b0);
    repeat (2) drive(4'b0000, 32'h0, 1'b0);

    // Lock held by requester 1.
    reset_pulse();
    repeat (10) drive(4'b0010, $urandom, 1'b1);
    repeat (2) drive(4'b0000, 32'h0, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_pulse();
      end else if ($urandom_range(0, 3) == 0) begin
        drive(4'($urandom), $urandom, 1'($urandom_range(0, 1)));
      end else begin
        drive(req, $urandom, lock);
      end
    end

    repeat (3) drive(4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    check("writes_drained", wr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
